// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo push arbiter and its round-robin picker.
package fifo_arb_pkg;

  localparam int STAT_W = 16;

  typedef logic [STAT_W-1:0] stat_t;

  // Index width for n items; a single item still needs one bit.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: scans from the slot after the last winner and
// remembers the winner as the new rotation point.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         valid,
  input  logic                    enable,
  output logic [NREQ-1:0]         gnt,
  output logic [idx_w(NREQ)-1:0]  idx
);

  localparam int IW = idx_w(NREQ);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic [IW-1:0] scan;
  logic          found;
  int            j;

  always_comb begin
    pick  = '0;
    scan  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      scan = IW'(j);
      if (!found && valid[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (enable && found && !rst) gnt[pick] = 1'b1;
  end

  assign idx = pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr <= IW'(NREQ - 1);
    else if (enable && |valid) rr_ptr <= pick;
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin sharing of one fifo write port with a single holding output stage.
// Optional per-producer drain and stall counters under FIFO_PUSH_ARB_STATS_EN.
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int BUSW = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [BUSW-1:0]           req_data [NREQ],
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_push,
  output logic [BUSW-1:0]           fifo_datain,
  output logic [$clog2(NREQ)-1:0]   gnt_id
`ifdef FIFO_PUSH_ARB_STATS_EN
  ,
  output stat_t                     acc_cnt [NREQ],
  output stat_t                     stall_cnt
`endif
);

  logic                    drain;
  logic                    load_ok;
  logic                    grant;
  logic [$clog2(NREQ)-1:0] arb_idx;

  // The stage may refill in the same cycle its word leaves, sustaining one word per clock.
  assign drain   = fifo_push && !fifo_full;
  assign load_ok = !fifo_push || !fifo_full;
  assign grant   = |req_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .enable (load_ok),
    .gnt    (req_ready),
    .idx    (arb_idx)
  );

  // Output stage: EMPTY when fifo_push is low, HOLD when high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_push   <= 1'b0;
      fifo_datain <= '0;
      gnt_id      <= '0;
    end else if (grant) begin
      fifo_push   <= 1'b1;
      fifo_datain <= req_data[arb_idx];
      gnt_id      <= arb_idx;
    end else if (drain) begin
      fifo_push   <= 1'b0;
    end
  end

`ifdef FIFO_PUSH_ARB_STATS_EN
  function automatic stat_t sat_inc(input stat_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Drained words are credited to the producer whose word sat in the stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) acc_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      if (drain) acc_cnt[gnt_id] <= sat_inc(acc_cnt[gnt_id]);
      if (fifo_push && fifo_full) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Bench for fifo_push_arb: directed grant-order checks plus a data scoreboard.
module tb_fifo_push_arb;

  localparam int NREQ = 4;
  localparam int BUSW = 32;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [BUSW-1:0]  req_data [NREQ];
  logic [NREQ-1:0]  req_ready;
  logic             fifo_full;
  logic             fifo_push;
  logic [BUSW-1:0]  fifo_datain;
  logic [1:0]       gnt_id;
`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [15:0]      acc_cnt [NREQ];
  logic [15:0]      stall_cnt;
`endif

  fifo_push_arb #(.NREQ(NREQ), .BUSW(BUSW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_push   (fifo_push),
    .fifo_datain (fifo_datain),
    .gnt_id      (gnt_id)
`ifdef FIFO_PUSH_ARB_STATS_EN
    ,
    .acc_cnt     (acc_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [31:0]  data;
  } exp_t;

  exp_t             sb [$];
  int               total = 0;
  int               bad = 0;
  int               drain_n = 0;
  int               hs_n = 0;
  int               seq = 1;
  logic [NREQ-1:0]  rdy_s;
  logic             push_s;
  logic [NREQ-1:0]  hs_mask;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe the cycle just before the coming edge: handshakes in, drains out
  task automatic sample();
    exp_t e;
    rdy_s   = req_ready;
    push_s  = fifo_push;
    hs_mask = '0;
    chk("onehot", 64'($onehot0(req_ready)), 1);
    if (fifo_push && !fifo_full) begin
      drain_n++;
      chk("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data", fifo_datain, e.data);
        chk("sb_id", gnt_id, e.id);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        sb.push_back('{i, req_data[i]});
        hs_mask[i] = 1'b1;
        hs_n++;
      end
    end
  endtask

  // Producers present a fresh word once their previous one has been taken
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs_mask[i]) begin
        req_data[i] = {4'(i), 28'(seq)};
        seq++;
      end
    end
  endtask

  initial begin
    int it;
    rst       = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) req_data[i] = {4'(i), 28'(100 + i)};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_push", fifo_push, 0);
    chk("rst_data", fifo_datain, 0);
    chk("rst_id", gnt_id, 0);
    chk("rst_ready", req_ready, 0);
    req_valid = 4'b1111;
    chk("rst_ready_valid", req_ready, 0);
    rst = 1'b0;

    // All producers valid, fifo never full
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("all_gnt", rdy_s, 64'(1 << (k % 4)));
      if (k > 0) chk("all_push", push_s, 1);
    end

    // Sparse requesters alternate
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("alt_gnt", rdy_s, (k % 2 == 0) ? 64'h1 : 64'h4);
    end

    // Full held while a known word sits in the stage
    req_valid = '0;
    tick();
    chk("idle_gnt", rdy_s, 0);
    req_data[3] = 32'hA5A5_0001;
    req_valid   = 4'b1000;
    tick();
    chk("hold_load", rdy_s, 4'b1000);
    fifo_full = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("full_push", push_s, 1);
      chk("full_data", fifo_datain, 32'hA5A5_0001);
      chk("full_ready", rdy_s, 0);
    end
    fifo_full = 1'b0;
    tick();
    chk("release_gnt", rdy_s, 4'b0001);

    // Wrap-around from index 3 to index 0
    req_valid = 4'b1000;
    tick();
    chk("wrap_pre", rdy_s, 4'b1000);
    req_valid = 4'b1001;
    tick();
    chk("wrap_0", rdy_s, 4'b0001);
    tick();
    chk("wrap_3", rdy_s, 4'b1000);

    // Asynchronous reset with a word pending
    req_valid = '0;
    tick();
    fifo_full = 1'b1;
    req_valid = 4'b0010;
    tick();
    chk("pend_gnt", rdy_s, 4'b0010);
    chk("pend_push", fifo_push, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_push", fifo_push, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_data", fifo_datain, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    fifo_full = 1'b0;
    req_valid = 4'b1111;
    tick();
    chk("post_rst_gnt", rdy_s, 4'b0001);
    req_valid = '0;
    it = 0;
    while ((fifo_push || sb.size() != 0) && it < 20) begin
      tick();
      it++;
    end
    chk("flush_bound", 64'(it < 20), 1);

    // Stream ten words from producer 1 with three stalled cycles
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    drain_n   = 0;
    hs_n      = 0;
    req_valid = 4'b0010;
    it = 0;
    while (drain_n < 10 && it < 60) begin
      fifo_full = (it == 3 || it == 5 || it == 6);
      tick();
      if (hs_n >= 10) req_valid = '0;
      it++;
    end
    fifo_full = 1'b0;
    chk("stream_drains", drain_n, 10);
    chk("stream_hs", hs_n, 10);
`ifdef FIFO_PUSH_ARB_STATS_EN
    chk("acc_cnt1", acc_cnt[1], 10);
    chk("acc_cnt0", acc_cnt[0], 0);
    chk("stall_cnt", stall_cnt, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
